// File: rtl/uart_frame_parser.sv
// Frame assembler behind uart_rx: HEADER, cmd, len, payload[len], checksum -> cmd/len/payload buffer.
// Latency: frame_valid/frame_err pulse one cycle after the rx_done of the deciding byte.
// Backpressure: none; every rx_done strobe is consumed, and stalled frames time out and are dropped.
module uart_frame_parser #(
    parameter logic [7:0] HEADER      = 8'hAA,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 200000,
    localparam int        AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int        LW          = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    data_byte,
    input  logic          rx_done,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [7:0]    frame_cmd,
    output logic [LW-1:0] frame_len,
    output logic          frame_valid,
    output logic          frame_err,
    output logic          busy
);

    localparam int          TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [AW:0] DEPTH = (AW + 1)'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        DATA,
        CHK
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    cmd_tmp, cmd_nxt;
    logic [LW-1:0] len_tmp, len_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [7:0]    sum, sum_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [7:0]    fcmd_nxt;
    logic [LW-1:0] flen_nxt;
    logic          valid_nxt;
    logic          err_nxt;
    logic          wr_en;
    logic          last_byte;

    logic [7:0]    pbuf [MAX_LEN];

    assign busy      = (state != IDLE);
    assign last_byte = (LW'(cnt) == (len_tmp - LW'(1)));

    // Addresses past the buffer depth read as zero rather than indexing out of range.
    assign rd_data = ({1'b0, rd_addr} < DEPTH) ? pbuf[rd_addr] : 8'h00;

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_tmp;
        len_nxt   = len_tmp;
        cnt_nxt   = cnt;
        sum_nxt   = sum;
        tcnt_nxt  = tcnt;
        fcmd_nxt  = frame_cmd;
        flen_nxt  = frame_len;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        wr_en     = 1'b0;

        if (rx_done) begin
            // A byte arriving on the expiry cycle still counts, so the timer is cleared first.
            tcnt_nxt = '0;
            case (state)
                IDLE: begin
                    if (data_byte == HEADER) begin
                        state_nxt = CMD;
                    end
                end
                CMD: begin
                    cmd_nxt   = data_byte;
                    sum_nxt   = data_byte;
                    state_nxt = LEN;
                end
                LEN: begin
                    if (data_byte > 8'(MAX_LEN)) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (data_byte == 8'h00) begin
                        len_nxt   = '0;
                        state_nxt = CHK;
                    end else begin
                        len_nxt   = data_byte[LW-1:0];
                        cnt_nxt   = '0;
                        sum_nxt   = sum + data_byte;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    wr_en   = 1'b1;
                    sum_nxt = sum + data_byte;
                    cnt_nxt = cnt + AW'(1);
                    if (last_byte) begin
                        state_nxt = CHK;
                    end
                end
                CHK: begin
                    if (data_byte == sum) begin
                        valid_nxt = 1'b1;
                        fcmd_nxt  = cmd_tmp;
                        flen_nxt  = len_tmp;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end else if (state != IDLE) begin
            if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                err_nxt   = 1'b1;
                tcnt_nxt  = '0;
                state_nxt = IDLE;
            end else begin
                tcnt_nxt = tcnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_tmp     <= '0;
            len_tmp     <= '0;
            cnt         <= '0;
            sum         <= '0;
            tcnt        <= '0;
            frame_cmd   <= '0;
            frame_len   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                pbuf[i] <= 8'h00;
            end
        end else begin
            state       <= state_nxt;
            cmd_tmp     <= cmd_nxt;
            len_tmp     <= len_nxt;
            cnt         <= cnt_nxt;
            sum         <= sum_nxt;
            tcnt        <= tcnt_nxt;
            frame_cmd   <= fcmd_nxt;
            frame_len   <= flen_nxt;
            frame_valid <= valid_nxt;
            frame_err   <= err_nxt;
            if (wr_en) begin
                pbuf[cnt] <= data_byte;
            end
        end
    end

endmodule
